icache: RTL and testbench



---
 rtl/icache_pkg.sv | 15 +
 rtl/icache_array.sv | 46 ++++
 rtl/icache.sv | 109 ++++++++++
 tb/tb_icache.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared constants and FSM encoding for the direct-mapped instruction cache.
package icache_pkg;

  localparam int unsigned TAG_W    = 3;
  localparam int unsigned INDEX_W  = 3;
  localparam int unsigned OFFSET_W = 2;
  localparam int unsigned BLOCK_W  = 128;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_READ = 2'd1,
    UPDATE   = 2'd2
  } icache_state_e;

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage: async clear, one write port, one combinational read port.
module icache_array
  import icache_pkg::*;
#(
  parameter int unsigned IndexW = INDEX_W,
  parameter int unsigned TagW   = TAG_W,
  parameter int unsigned BlockW = BLOCK_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_we,
  input  logic [IndexW-1:0] i_waddr,
  input  logic [TagW-1:0]   i_wtag,
  input  logic [BlockW-1:0] i_wdata,
  input  logic [IndexW-1:0] i_raddr,
  output logic              o_valid,
  output logic [TagW-1:0]   o_tag,
  output logic [BlockW-1:0] o_data
);

  localparam int unsigned NumLines = 1 << IndexW;

  logic              r_valid [NumLines];
  logic [TagW-1:0]   r_tag   [NumLines];
  logic [BlockW-1:0] r_data  [NumLines];

  // Data is cleared too so the instruction output reads zero out of reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NumLines; i++) begin
        r_valid[i] <= 1'b0;
        r_tag[i]   <= '0;
        r_data[i]  <= '0;
      end
    end else if (i_we) begin
      r_valid[i_waddr] <= 1'b1;
      r_tag[i_waddr]   <= i_wtag;
      r_data[i_waddr]  <= i_wdata;
    end
  end

  assign o_valid = r_valid[i_raddr];
  assign o_tag   = r_tag[i_raddr];
  assign o_data  = r_data[i_raddr];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: zero-latency hits, block fill on miss.
module icache
  import icache_pkg::*;
#(
  parameter int unsigned NUM_BLOCKS  = 1 << INDEX_W,
  parameter int unsigned BLOCK_BYTES = BLOCK_W / 8,
  parameter int unsigned ADDR_BITS   = TAG_W + INDEX_W + OFFSET_W + 2
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic [31:0]                     PC,
  output logic [31:0]                     INSTRUCTION,
  output logic                            BUSYWAIT,
  output logic                            mem_read,
  output logic [ADDR_BITS-OFFSET_W-3:0]   mem_address,
  input  logic [BLOCK_BYTES*8-1:0]        mem_readdata,
  input  logic                            mem_busywait
);

  localparam int unsigned IndexW  = $clog2(NUM_BLOCKS);
  localparam int unsigned OffsetW = $clog2(BLOCK_BYTES / 4);
  localparam int unsigned TagW    = ADDR_BITS - IndexW - OffsetW - 2;
  localparam int unsigned BlockW  = BLOCK_BYTES * 8;

  icache_state_e r_state, w_next_state;

  logic [TagW-1:0]    w_tag;
  logic [IndexW-1:0]  w_index;
  logic [OffsetW-1:0] w_offset;
  logic [TagW-1:0]    r_miss_tag;
  logic [IndexW-1:0]  r_miss_index;
  logic               w_line_valid;
  logic [TagW-1:0]    w_line_tag;
  logic [BlockW-1:0]  w_line_data;
  logic               w_hit;
  logic               w_fill;
  logic               w_busywait;
  logic               w_unused_pc;

  assign w_tag       = PC[ADDR_BITS-1 -: TagW];
  assign w_index     = PC[ADDR_BITS-TagW-1 -: IndexW];
  assign w_offset    = PC[OffsetW+1:2];
  // Upper bits alias (1 KB space) and byte-in-word bits are don't-care.
  assign w_unused_pc = ^{PC[31:ADDR_BITS], PC[1:0]};

  icache_array #(
    .IndexW (IndexW),
    .TagW   (TagW),
    .BlockW (BlockW)
  ) u_array (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .i_we    (w_fill),
    .i_waddr (r_miss_index),
    .i_wtag  (r_miss_tag),
    .i_wdata (mem_readdata),
    .i_raddr (w_index),
    .o_valid (w_line_valid),
    .o_tag   (w_line_tag),
    .o_data  (w_line_data)
  );

  assign w_hit       = w_line_valid & (w_line_tag == w_tag);
  assign INSTRUCTION = w_line_data[w_offset*32 +: 32];
  assign mem_address = {r_miss_tag, r_miss_index};
  assign BUSYWAIT    = w_busywait & ~RESET;

  always_comb begin
    w_next_state = r_state;
    w_busywait   = 1'b0;
    mem_read     = 1'b0;
    w_fill       = 1'b0;
    case (r_state)
      IDLE: begin
        w_busywait = ~w_hit;
        if (!w_hit) w_next_state = MEM_READ;
      end
      MEM_READ: begin
        mem_read   = 1'b1;
        w_busywait = 1'b1;
        if (!mem_busywait) begin
          w_fill       = 1'b1;
          w_next_state = UPDATE;
        end
      end
      UPDATE: begin
        w_busywait   = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // The fill address is captured on the miss so later PC changes cannot corrupt it.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state      <= IDLE;
      r_miss_tag   <= '0;
      r_miss_index <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == IDLE && !w_hit) begin
        r_miss_tag   <= w_tag;
        r_miss_index <= w_index;
      end
    end
  end

endmodule

// File: tb/tb_icache.sv
// Randomized self-checking bench for icache against a line-level behavioural model.
module tb_icache;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [31:0]  PC;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         mem_read;
  logic [5:0]   mem_address;
  logic [127:0] mem_readdata;
  logic         mem_busywait;

  icache u_dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .PC           (PC),
    .INSTRUCTION  (INSTRUCTION),
    .BUSYWAIT     (BUSYWAIT),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait)
  );

  always #5 CLK = ~CLK;

  // Model: what each of the 8 lines holds, as the CPU would observe it.
  logic         m_valid [8];
  logic [2:0]   m_tag   [8];
  logic [127:0] m_data  [8];
  logic [127:0] next_blk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
      m_data[i]  = '0;
    end
  endtask

  function automatic logic [127:0] rand_blk();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // One fetch. On a miss, memory stays busy for m cycles after mem_read rises; the task
  // returns in the first IDLE cycle after the fill so the caller can re-fetch.
  task automatic do_fetch(input logic [31:0] pc, input int m, input bit swap,
                          input logic [31:0] pc2);
    logic [2:0]   tg;
    logic [2:0]   ix;
    logic [1:0]   off;
    logic [127:0] blk;
    int           stall;
    PC           = pc;
    mem_busywait = 1'b1;
    #1;
    tg  = pc[9:7];
    ix  = pc[6:4];
    off = pc[3:2];
    if (m_valid[ix] && m_tag[ix] == tg) begin
      check_eq("hit_busywait", BUSYWAIT, 0);
      check_eq("hit_mem_read", mem_read, 0);
      check_eq("hit_instr", INSTRUCTION, m_data[ix][off*32 +: 32]);
      @(negedge CLK);
    end else begin
      check_eq("miss_busywait", BUSYWAIT, 1);
      check_eq("miss_idle_rd", mem_read, 0);
      stall = 0;
      for (int k = 1; k <= m; k++) begin
        @(negedge CLK); #1;
        check_eq("busy_mem_read", mem_read, 1);
        check_eq("busy_mem_addr", mem_address, {tg, ix});
        if (BUSYWAIT) stall++;
        if (swap && k == 1) PC = pc2;
      end
      blk = next_blk;
      next_blk = rand_blk();
      @(posedge CLK); #1;
      mem_busywait = 1'b0;
      mem_readdata = blk;
      if (swap && m == 0) PC = pc2;
      @(negedge CLK); #1;
      check_eq("cap_mem_read", mem_read, 1);
      check_eq("cap_mem_addr", mem_address, {tg, ix});
      if (BUSYWAIT) stall++;
      @(negedge CLK); #1;
      check_eq("upd_mem_read", mem_read, 0);
      if (BUSYWAIT) stall++;
      mem_busywait = 1'b1;
      mem_readdata = rand_blk();
      m_valid[ix] = 1'b1;
      m_tag[ix]   = tg;
      m_data[ix]  = blk;
      @(negedge CLK); #1;
      check_eq("stall_cycles", stall, m + 2);
    end
  endtask

  initial begin
    RESET        = 1'b1;
    PC           = 32'h0;
    mem_busywait = 1'b1;
    mem_readdata = '0;
    model_clear();
    next_blk = 128'h33221100_77665544_bbaa9988_00000005;
    repeat (2) @(negedge CLK);
    #1;
    check_eq("rst_busywait", BUSYWAIT, 0);
    check_eq("rst_mem_read", mem_read, 0);
    check_eq("rst_mem_addr", mem_address, 0);
    check_eq("rst_instr", INSTRUCTION, 0);
    RESET = 1'b0;

    do_fetch(32'h000, 5, 0, 0);
    do_fetch(32'h000, 0, 0, 0);
    check_eq("blk0_word0", INSTRUCTION, 32'h00000005);
    do_fetch(32'h004, 0, 0, 0);
    do_fetch(32'h008, 0, 0, 0);
    do_fetch(32'h00C, 0, 0, 0);
    do_fetch(32'h400, 0, 0, 0);
    do_fetch(32'h080, 2, 0, 0);
    do_fetch(32'h080, 0, 0, 0);
    do_fetch(32'h000, 1, 0, 0);
    do_fetch(32'h000, 0, 0, 0);
    do_fetch(32'h3FC, 3, 0, 0);
    do_fetch(32'h3FC, 0, 0, 0);

    // Reset mid-fill: the line must not be installed.
    PC = 32'h2A8;
    #1;
    check_eq("pre_rst_miss", BUSYWAIT, 1);
    @(negedge CLK); #1;
    check_eq("pre_rst_rd", mem_read, 1);
    RESET = 1'b1;
    #1;
    check_eq("midrst_mem_read", mem_read, 0);
    check_eq("midrst_busywait", BUSYWAIT, 0);
    check_eq("midrst_mem_addr", mem_address, 0);
    check_eq("midrst_instr", INSTRUCTION, 0);
    model_clear();
    @(negedge CLK);
    RESET = 1'b0;
    do_fetch(32'h2A8, 2, 0, 0);
    do_fetch(32'h2A8, 0, 0, 0);

    // PC moves mid-fill: line 0 still gets tag 0, then 0x010 misses on its own.
    do_fetch(32'h000, 3, 1, 32'h010);
    #1;
    check_eq("swap_miss", BUSYWAIT, 1);
    do_fetch(32'h010, 1, 0, 0);
    do_fetch(32'h010, 0, 0, 0);
    do_fetch(32'h000, 0, 0, 0);

    for (int i = 0; i < 80; i++) begin
      logic [31:0] rpc;
      rpc = $urandom() & 32'hFFFF_F3FC;
      rpc[9:4] = ($urandom_range(0, 3) == 0) ? 6'($urandom()) : {1'b0, 5'($urandom_range(0, 9))};
      do_fetch(rpc, $urandom_range(0, 4), 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
